// File: rtl/core_mem_pkg.sv
// Shared types and default sizes for the Core's memory arbiter.
// The owner enum tags which requester a read response belongs to.
package core_mem_pkg;

  localparam int CORE_ADDR_W   = 16;
  localparam int CORE_DATA_W   = 16;
  localparam int CORE_MAX_WAIT = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

endpackage

// File: rtl/core_mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store.
// Load/store has fixed priority; fetch is forced through after MAX_WAIT denied cycles.
module core_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int ADDR_W   = CORE_ADDR_W,
  parameter int DATA_W   = CORE_DATA_W,
  parameter int MAX_WAIT = CORE_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] starveCnt_q, starveCnt_d;
  logic             forceIf;

  // Grants are qualified with rst_n so nothing reaches memory while reset is held.
  always_comb begin
    forceIf = (starveCnt_q == CNT_W'(MAX_WAIT));
    if_gnt  = rst_n & if_req & (~ls_req | forceIf);
    ls_gnt  = rst_n & ls_req & ~(if_req & forceIf);
  end

  always_comb begin
    mem_en    = if_gnt | ls_gnt;
    mem_we    = ls_gnt & ls_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (ls_gnt) begin
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (ls_gnt && !ls_we) begin
      owner_d = OWN_LS;
    end
  end

  // Saturating count of consecutive cycles where fetch asked and lost.
  always_comb begin
    starveCnt_d = '0;
    if (if_req && !if_gnt) begin
      if (starveCnt_q == CNT_W'(MAX_WAIT)) begin
        starveCnt_d = starveCnt_q;
      end else begin
        starveCnt_d = starveCnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_NONE;
      starveCnt_q <= '0;
    end else begin
      owner_q     <= owner_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  assign if_rvalid = (owner_q == OWN_IF);
  assign ls_rvalid = (owner_q == OWN_LS);
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Randomized bench for core_mem_arbiter with a simple memory and a cycle-level
// reference model of arbitration, starvation and read returns.
module tb_core_mem_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [15:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [15:0] ls_addr = '0;
  logic [15:0] ls_wdata = '0;
  logic        ls_gnt, ls_rvalid;
  logic [15:0] ls_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] memRdata;

  int checks = 0;
  int failures = 0;

  logic [15:0] refMem [0:255];
  int          waitCnt;
  int          respKind;
  logic [15:0] respData;

  core_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MAXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (memRdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] seedWord(input int a);
    if (a == 1) return 16'hA5A5;
    return 16'((a * 257) ^ 16'h5A3C);
  endfunction

  // Single-port synchronous memory; the command is captured mid-cycle so it
  // cannot race with the arbiter's own register updates at the edge.
  initial begin
    logic        capEn, capWe;
    logic [7:0]  capAddr;
    logic [15:0] capData;
    logic [15:0] mem [0:255];
    for (int i = 0; i < 256; i++) mem[i] = seedWord(i);
    memRdata = '0;
    forever begin
      @(negedge clk);
      capEn   = mem_en;
      capWe   = mem_we;
      capAddr = mem_addr[7:0];
      capData = mem_wdata;
      @(posedge clk);
      if (capEn) begin
        if (capWe) mem[capAddr] = capData;
        else memRdata <= mem[capAddr];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One bus cycle: drive after the edge, check at the falling edge, then
  // advance the reference model to what the next edge should produce.
  task automatic applyStimulus(input logic iReq, input logic [15:0] iAddr,
                               input logic lReq, input logic lWe,
                               input logic [15:0] lAddr, input logic [15:0] lData);
    logic        expIf, expLs;
    logic [15:0] expAddr, expWdata;
    @(posedge clk);
    #1;
    if_req   = iReq;
    if_addr  = iAddr;
    ls_req   = lReq;
    ls_we    = lWe;
    ls_addr  = lAddr;
    ls_wdata = lData;
    @(negedge clk);
    expIf    = iReq && (!lReq || waitCnt >= MAXW);
    expLs    = lReq && !expIf;
    expAddr  = expIf ? iAddr : (expLs ? lAddr : 16'h0);
    expWdata = expLs ? lData : 16'h0;
    checkOutput("if_gnt", 32'(if_gnt), 32'(expIf));
    checkOutput("ls_gnt", 32'(ls_gnt), 32'(expLs));
    checkOutput("mem_en", 32'(mem_en), 32'(expIf || expLs));
    checkOutput("mem_we", 32'(mem_we), 32'(expLs && lWe));
    checkOutput("mem_addr", 32'(mem_addr), 32'(expAddr));
    checkOutput("mem_wdata", 32'(mem_wdata), 32'(expWdata));
    checkOutput("if_rvalid", 32'(if_rvalid), 32'(respKind == 1));
    checkOutput("ls_rvalid", 32'(ls_rvalid), 32'(respKind == 2));
    if (respKind == 1) checkOutput("if_rdata", 32'(if_rdata), 32'(respData));
    if (respKind == 2) checkOutput("ls_rdata", 32'(ls_rdata), 32'(respData));
    respKind = 0;
    if (expIf) begin
      respKind = 1;
      respData = refMem[iAddr[7:0]];
    end else if (expLs && !lWe) begin
      respKind = 2;
      respData = refMem[lAddr[7:0]];
    end
    if (expLs && lWe) refMem[lAddr[7:0]] = lData;
    if (iReq && !expIf) waitCnt = (waitCnt < MAXW) ? waitCnt + 1 : MAXW;
    else waitCnt = 0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_if_gnt"}, 32'(if_gnt), 32'(0));
    checkOutput({tag, "_ls_gnt"}, 32'(ls_gnt), 32'(0));
    checkOutput({tag, "_if_rvalid"}, 32'(if_rvalid), 32'(0));
    checkOutput({tag, "_ls_rvalid"}, 32'(ls_rvalid), 32'(0));
    checkOutput({tag, "_mem_en"}, 32'(mem_en), 32'(0));
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'(0));
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) refMem[i] = seedWord(i);
    waitCnt  = 0;
    respKind = 0;
    respData = '0;

    // Requests held during reset must not be granted.
    if_req   = 1'b1;
    if_addr  = 16'h0005;
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 16'h0006;
    ls_wdata = 16'hBEEF;
    #12;
    checkResetOutputs("reset");
    if_req = 1'b0;
    ls_req = 1'b0;
    ls_we  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Lone fetch of the preloaded 0xA5A5 word.
    applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);

    // Store then load of the same address.
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h1234);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);

    // Sustained contention: fetch should break through every fifth cycle.
    for (int i = 0; i < 11; i++)
      applyStimulus(1'b1, 16'h0020, 1'b1, 1'b0, 16'(16'h0030 + i), 16'h0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);

    // Back-to-back fetches with no bubble.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 16'(i), 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);

    // Withdrawn fetch must leave no residual starvation credit.
    applyStimulus(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0041, 16'h0);
    applyStimulus(1'b0, 16'h0040, 1'b1, 1'b0, 16'h0042, 16'h0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 16'h0043, 1'b1, 1'b1, 16'(16'h0050 + i), 16'(16'hC000 + i));
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset asserted while a fetch response is due.
    applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk);
    #2;
    ls_req = 1'b1;
    rst_n  = 1'b0;
    #1;
    checkResetOutputs("midreset");
    if_req = 1'b0;
    ls_req = 1'b0;
    respKind = 0;
    waitCnt  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b1, 16'h0007, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);

    // Random traffic, biased towards contention.
    for (int i = 0; i < 1500; i++)
      applyStimulus($urandom_range(0, 9) < 7, 16'($urandom_range(0, 255)),
                    $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                    16'($urandom_range(0, 255)), 16'($urandom));
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
